// File: rtl/alu_issue_ctrl.sv
// Issue controller: decodes a MIPS instruction, drives an external ALU and returns the result over a valid/ready handshake.
// Optional define ALU_ISSUE_IMM_LOGIC_EN enables decoding of andi/ori with zero-extended immediates.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_wr_en,
    output logic        out_branch_taken,
    output logic        out_illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_HOLD
    } state_t;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_ILL = 4'b1111;

    state_t state, state_nxt;
    logic   accept;

    logic [3:0]  dec_ctrl;
    logic [31:0] dec_b;
    logic        dec_wr, dec_beq, dec_bne, dec_ill;

    logic        op_wr, op_beq, op_bne, op_ill;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;

    assign opcode            = instr[31:26];
    assign funct             = instr[5:0];
    assign unused_instr_bits = ^instr[25:16];

    assign in_ready  = (state == S_IDLE) || (state == S_HOLD && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_HOLD);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) state_nxt = S_EXEC;
            S_EXEC: state_nxt = S_HOLD;
            S_HOLD: begin
                if (out_ready && in_valid)  state_nxt = S_EXEC;
                else if (out_ready)         state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dec_ctrl = CTRL_ILL;
        dec_b    = rt_data;
        dec_wr   = 1'b0;
        dec_beq  = 1'b0;
        dec_bne  = 1'b0;
        dec_ill  = 1'b0;
        case (opcode)
            6'h00: begin
                dec_wr = 1'b1;
                case (funct)
                    6'h20:   dec_ctrl = CTRL_ADD;
                    6'h22:   dec_ctrl = CTRL_SUB;
                    6'h24:   dec_ctrl = CTRL_AND;
                    6'h25:   dec_ctrl = CTRL_OR;
                    6'h2A:   dec_ctrl = CTRL_SLT;
                    default: begin
                        dec_wr  = 1'b0;
                        dec_ill = 1'b1;
                    end
                endcase
            end
            6'h08, 6'h23, 6'h2B: begin
                dec_ctrl = CTRL_ADD;
                dec_b    = {{16{instr[15]}}, instr[15:0]};
                dec_wr   = (opcode == 6'h08);
            end
            6'h04: begin
                dec_ctrl = CTRL_SUB;
                dec_beq  = 1'b1;
            end
            6'h05: begin
                dec_ctrl = CTRL_SUB;
                dec_bne  = 1'b1;
            end
`ifdef ALU_ISSUE_IMM_LOGIC_EN
            6'h0C, 6'h0D: begin
                dec_ctrl = (opcode == 6'h0C) ? CTRL_AND : CTRL_OR;
                dec_b    = {16'h0000, instr[15:0]};
                dec_wr   = 1'b1;
            end
`endif
            default: dec_ill = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operands and decoded qualifiers are held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= CTRL_ILL;
            op_wr    <= 1'b0;
            op_beq   <= 1'b0;
            op_bne   <= 1'b0;
            op_ill   <= 1'b0;
        end else if (accept) begin
            alu_a    <= rs_data;
            alu_b    <= dec_b;
            alu_ctrl <= dec_ctrl;
            op_wr    <= dec_wr;
            op_beq   <= dec_beq;
            op_bne   <= dec_bne;
            op_ill   <= dec_ill;
        end
    end

    // Result is captured only on the EXEC->HOLD edge, so it stays stable through backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result       <= '0;
            out_wr_en        <= 1'b0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b0;
        end else if (state == S_EXEC) begin
            out_result       <= op_ill ? 32'h0 : alu_result;
            out_wr_en        <= op_wr;
            out_branch_taken <= (op_beq && alu_zero) || (op_bne && !alu_zero);
            out_illegal      <= op_ill;
        end
    end

endmodule
